// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM dynamic-programming port responder.
package dcm_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_GO_CHK  = 3'd2,
        ST_DATA    = 3'd3,
        ST_END_CHK = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_BUSY    = 3'd6
    } state_e;

    localparam logic       OP_LOAD_D   = 1'b0;
    localparam logic       OP_LOAD_M   = 1'b1;
    localparam int         DATA_BITS   = 8;
    localparam logic [7:0] MIN_MULT_M1 = 8'd1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dcm_prog_deser.sv
// LSB-first serial-to-parallel shifter with bit counter for PROGDATA payloads.
module dcm_prog_deser
    import dcm_prog_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 last_bit,
    output logic                 full
);

    logic [DATA_BITS-1:0] data_r;
    logic [3:0]           cnt_r;

    // Shift register and bit counter; new bits enter at the MSB so the first bit ends at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            cnt_r  <= 4'd0;
        end else if (clear) begin
            data_r <= '0;
            cnt_r  <= 4'd0;
        end else if (shift) begin
            data_r <= {bit_in, data_r[DATA_BITS-1:1]};
            cnt_r  <= cnt_r + 4'd1;
        end else begin
            data_r <= data_r;
            cnt_r  <= cnt_r;
        end
    end

    assign data     = data_r;
    assign last_bit = (cnt_r == 4'(DATA_BITS - 1));
    assign full     = (cnt_r == 4'(DATA_BITS));

endmodule

// File: rtl/dcm_prog_responder.sv
// Receive side of the DCM PROGEN/PROGDATA port: decodes LoadD/LoadM/GO and drives PROGDONE.
// Optional saturating error counter port enabled by DCM_PROG_ERRCNT_EN.
module dcm_prog_responder
    import dcm_prog_pkg::*;
#(
    parameter int INITIAL_MULTIPLIER = 16,
    parameter int INITIAL_DIVIDER    = 9,
    parameter int GO_LATENCY         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       prog_en,
    input  logic       prog_data,
    output logic       prog_done,
    output logic [7:0] mult_m1,
    output logic [7:0] div_d1,
    output logic       cfg_valid,
    output logic       frame_err
`ifdef DCM_PROG_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] MULT_RST = 8'(INITIAL_MULTIPLIER - 1);
    localparam logic [7:0] DIV_RST  = 8'(INITIAL_DIVIDER - 1);
    localparam logic [7:0] LAT_LOAD = 8'(GO_LATENCY);

    state_e     state_r, state_s;
    logic       op_r, op_s;
    logic [7:0] pend_d_r, pend_d_s, pend_m_r, pend_m_s;
    logic [7:0] mult_r, mult_s, div_r, div_s;
    logic [7:0] lat_r, lat_s;
    logic       done_r, done_s, cfg_r, cfg_s, err_r, err_s;
    logic       en_q_r;
    logic       shift_s, clear_s, last_bit_s, full_s;
    logic [7:0] shreg_s;

    dcm_prog_deser u_deser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .shift    (shift_s),
        .bit_in   (prog_data),
        .data     (shreg_s),
        .last_bit (last_bit_s),
        .full     (full_s)
    );

    // Frame decoder next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        pend_d_s = pend_d_r;
        pend_m_s = pend_m_r;
        mult_s   = mult_r;
        div_s    = div_r;
        lat_s    = lat_r;
        done_s   = done_r;
        cfg_s    = 1'b0;
        err_s    = 1'b0;
        shift_s  = 1'b0;
        clear_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = 1'b1;
                if (prog_en) begin
                    done_s  = 1'b0;
                    state_s = prog_data ? ST_CMD : ST_GO_CHK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                clear_s = 1'b1;
                if (prog_en) begin
                    op_s    = prog_data;
                    state_s = ST_DATA;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DRAIN;
                end
            end
            ST_DATA: begin
                if (prog_en) begin
                    shift_s = 1'b1;
                    state_s = last_bit_s ? ST_END_CHK : ST_DATA;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DRAIN;
                end
            end
            ST_END_CHK: begin
                if (!prog_en && full_s) begin
                    if (op_r == OP_LOAD_M) begin
                        pend_m_s = shreg_s;
                    end else begin
                        pend_d_s = shreg_s;
                    end
                    state_s = ST_IDLE;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DRAIN;
                end
            end
            ST_GO_CHK: begin
                if (!prog_en) begin
                    // M must be at least 2; a rejected GO still runs the lock latency.
                    if (pend_m_r >= MIN_MULT_M1) begin
                        mult_s = pend_m_r;
                        div_s  = pend_d_r;
                        cfg_s  = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                    lat_s   = LAT_LOAD;
                    state_s = ST_BUSY;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_s = prog_en ? ST_DRAIN : ST_IDLE;
            end
            ST_BUSY: begin
                if (prog_en && !en_q_r) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
                if (lat_r <= 8'd1) begin
                    lat_s   = 8'd0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    lat_s   = lat_r - 8'd1;
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_LOAD_D;
            pend_d_r <= DIV_RST;
            pend_m_r <= MULT_RST;
            mult_r   <= MULT_RST;
            div_r    <= DIV_RST;
            lat_r    <= 8'd0;
            done_r   <= 1'b1;
            cfg_r    <= 1'b0;
            err_r    <= 1'b0;
            en_q_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            pend_d_r <= pend_d_s;
            pend_m_r <= pend_m_s;
            mult_r   <= mult_s;
            div_r    <= div_s;
            lat_r    <= lat_s;
            done_r   <= done_s;
            cfg_r    <= cfg_s;
            err_r    <= err_s;
            en_q_r   <= prog_en;
        end
    end

`ifdef DCM_PROG_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of frame_err pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (err_s) begin
            err_cnt_r <= sat_inc8(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`endif

    assign prog_done = done_r;
    assign mult_m1   = mult_r;
    assign div_d1    = div_r;
    assign cfg_valid = cfg_r;
    assign frame_err = err_r;

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed bench for dcm_prog_responder: transaction table plus hand-written corner sequences.
module tb_dcm_prog_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_en;
    logic       prog_data;
    logic       prog_done;
    logic [7:0] mult_m1;
    logic [7:0] div_d1;
    logic       cfg_valid;
    logic       frame_err;
`ifdef DCM_PROG_ERRCNT_EN
    logic [7:0] err_count;
`endif

    dcm_prog_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_en   (prog_en),
        .prog_data (prog_data),
        .prog_done (prog_done),
        .mult_m1   (mult_m1),
        .div_d1    (div_d1),
        .cfg_valid (cfg_valid),
        .frame_err (frame_err)
`ifdef DCM_PROG_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         op;        // 0 LoadD, 1 LoadM, 2 GO
        logic [7:0] val;
        int         gap;
        logic       exp_cfg;
        int         exp_err;
        logic [7:0] exp_mult;
        logic [7:0] exp_div;
    } vec_t;

    vec_t vecs[12];

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   cfg_seen = 0;
    int   err_seen = 0;
    int   done_rise_cyc = -1;
    logic prev_done = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic en, input logic d);
        prog_en   = en;
        prog_data = d;
        @(posedge clk);
        #1;
        cyc++;
        if (cfg_valid) cfg_seen++;
        if (frame_err) err_seen++;
        if (prog_done && !prev_done) done_rise_cyc = cyc;
        prev_done = prog_done;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic load(input logic op, input logic [7:0] v);
        drive(1'b1, 1'b1);
        check("done_low_on_frame", prog_done, 0);
        drive(1'b1, op);
        for (int i = 0; i < 8; i++) drive(1'b1, v[i]);
        drive(1'b0, 1'b0);
    endtask

    task automatic go(input int glitch_at, input logic exp_cfg,
                      input logic [7:0] exp_mult, input logic [7:0] exp_div);
        int confirm;
        int n;
        drive(1'b1, 1'b0);
        check("done_low_on_go", prog_done, 0);
        drive(1'b0, 1'b0);
        confirm = cyc;
        check("cfg_at_confirm", cfg_valid, exp_cfg);
        check("err_at_confirm", frame_err, !exp_cfg);
        check("mult_at_confirm", mult_m1, exp_mult);
        check("div_at_confirm", div_d1, exp_div);
        done_rise_cyc = -1;
        n = 0;
        while (done_rise_cyc < 0 && n < 300) begin
            if (n == glitch_at) drive(1'b1, 1'b1);
            else drive(1'b0, 1'b0);
            n++;
            if (n == 1) check("cfg_falls", cfg_valid, 0);
        end
        check("done_latency", done_rise_cyc - confirm, 16);
    endtask

    initial begin
        int e0;
        int c0;

        vecs[0]  = '{0,   8, 3, 1'b0, 0,  15,   8};
        vecs[1]  = '{1,  39, 2, 1'b0, 0,  15,   8};
        vecs[2]  = '{2,   0, 1, 1'b1, 0,  39,   8};
        vecs[3]  = '{0,   3, 0, 1'b0, 0,  39,   8};
        vecs[4]  = '{2,   0, 1, 1'b1, 0,  39,   3};
        vecs[5]  = '{1,   0, 1, 1'b0, 0,  39,   3};
        vecs[6]  = '{2,   0, 1, 1'b0, 1,  39,   3};
        vecs[7]  = '{1,   1, 1, 1'b0, 0,  39,   3};
        vecs[8]  = '{2,   0, 1, 1'b1, 0,   1,   3};
        vecs[9]  = '{0, 255, 1, 1'b0, 0,   1,   3};
        vecs[10] = '{1, 255, 1, 1'b0, 0,   1,   3};
        vecs[11] = '{2,   0, 1, 1'b1, 0, 255, 255};

        rst_n     = 1'b0;
        prog_en   = 1'b0;
        prog_data = 1'b0;
        #12;
        rst_n = 1'b1;
        idle(3);
        check("rst_done", prog_done, 1);
        check("rst_mult", mult_m1, 15);
        check("rst_div", div_d1, 8);
        check("rst_no_cfg", cfg_seen, 0);
        check("rst_no_err", err_seen, 0);
`ifdef DCM_PROG_ERRCNT_EN
        check("rst_errcnt", err_count, 0);
`endif

        for (int k = 0; k < 12; k++) begin
            e0 = err_seen;
            c0 = cfg_seen;
            if (vecs[k].op == 2) go(-1, vecs[k].exp_cfg, vecs[k].exp_mult, vecs[k].exp_div);
            else load(vecs[k].op[0], vecs[k].val);
            idle(vecs[k].gap);
            check($sformatf("vec%0d_mult", k), mult_m1, vecs[k].exp_mult);
            check($sformatf("vec%0d_div", k), div_d1, vecs[k].exp_div);
            check($sformatf("vec%0d_cfg", k), cfg_seen - c0, vecs[k].exp_cfg);
            check($sformatf("vec%0d_err", k), err_seen - e0, vecs[k].exp_err);
        end

        // Truncated LoadM after 5 data bits must not overwrite pending M=50.
        load(1'b1, 8'd50);
        idle(1);
        e0 = err_seen;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, i[0]);
        drive(1'b0, 1'b0);
        idle(3);
        check("trunc_err", err_seen - e0, 1);
        check("trunc_done_low", prog_done, 0);
        e0 = err_seen;
        go(-1, 1'b1, 8'd50, 8'd255);
        check("trunc_go_err", err_seen - e0, 0);

        // prog_en held high for 12 cycles: one error, drain, then a valid frame.
        e0 = err_seen;
        repeat (12) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        idle(2);
        check("long_err", err_seen - e0, 1);
        load(1'b0, 8'd7);
        idle(1);
        go(-1, 1'b1, 8'd50, 8'd7);

        // GO_CHK seeing prog_en high is an error and leaves prog_done low.
        e0 = err_seen;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        idle(2);
        check("gochk_err", err_seen - e0, 1);
        check("gochk_done_low", prog_done, 0);

        // A prog_en pulse during BUSY flags an error but does not disturb the latency.
        e0 = err_seen;
        go(3, 1'b1, 8'd50, 8'd7);
        check("busy_glitch_err", err_seen - e0, 1);
        idle(2);

        // Async reset three cycles into BUSY discards active and pending values.
        load(1'b1, 8'd39);
        idle(1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("pre_rst_mult", mult_m1, 39);
        idle(3);
        check("pre_rst_done", prog_done, 0);
        rst_n = 1'b0;
        #1;
        check("arst_done", prog_done, 1);
        check("arst_mult", mult_m1, 15);
        check("arst_div", div_d1, 8);
        check("arst_cfg", cfg_valid, 0);
        check("arst_err", frame_err, 0);
        #2;
        rst_n     = 1'b1;
        prev_done = prog_done;
        idle(2);
        go(-1, 1'b1, 8'd15, 8'd8);

`ifdef DCM_PROG_ERRCNT_EN
        // 300 short error frames saturate the counter.
        e0 = err_seen;
        repeat (300) begin
            drive(1'b1, 1'b1);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
        end
        idle(2);
        check("errcnt_pulses", err_seen - e0, 300);
        check("errcnt_sat", err_count, 255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
